// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request, HI/LO write and result signals of the muldiv unit
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, we_hi, we_lo, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv.sv
// rtl/muldiv.sv - 32-bit iterative multiply/divide unit with HI/LO registers
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
    DIV  = 2'd2,
`endif
    FIX  = 2'd3
  } state_t;

  state_t      state;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [4:0]  cnt;
  logic [31:0] rh;
  logic [31:0] rl;
  logic [31:0] mc;
  logic        neg_q;
`ifdef MULDIV_DIV_EN
  logic        neg_r;
  logic        op_div;
`endif

  logic        sa;
  logic        sb;
  logic        accept;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;

  assign sa    = bus.op[0] & bus.a[31];
  assign sb    = bus.op[0] & bus.b[31];
  assign mag_a = sa ? (~bus.a + 32'd1) : bus.a;
  assign mag_b = sb ? (~bus.b + 32'd1) : bus.b;

`ifdef MULDIV_DIV_EN
  assign accept = bus.start & ~busy_q;
`else
  assign accept = bus.start & ~busy_q & ~bus.op[1];
`endif

  // rh:rl is the running product; the multiplier is consumed from rl[0]
  assign mul_sum  = {1'b0, rh} + (rl[0] ? {1'b0, mc} : 33'd0);
  assign prod_fix = neg_q ? (~{rh, rl} + 64'd1) : {rh, rl};

`ifdef MULDIV_DIV_EN
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // rh holds the partial remainder, rl shifts dividend out and quotient in
  assign rem_shift = {rh, rl[31]};
  assign rem_ge    = rem_shift >= {1'b0, mc};
  assign q_fix     = neg_q ? (~rl + 32'd1) : rl;
  assign r_fix     = neg_r ? (~rh + 32'd1) : rh;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      cnt    <= 5'd0;
      rh     <= 32'd0;
      rl     <= 32'd0;
      mc     <= 32'd0;
      neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r  <= 1'b0;
      op_div <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (bus.we_hi) hi_q <= bus.wd;
        if (bus.we_lo) lo_q <= bus.wd;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            cnt    <= 5'd0;
            rh     <= 32'd0;
`ifdef MULDIV_DIV_EN
            op_div <= bus.op[1];
            if (bus.op[1]) begin
              rl    <= mag_a;
              mc    <= mag_b;
              // a zero divisor must leave the all-ones quotient unsigned
              neg_q <= (sa ^ sb) & (|bus.b);
              neg_r <= sa;
              state <= DIV;
            end else begin
              rl    <= mag_b;
              mc    <= mag_a;
              neg_q <= sa ^ sb;
              neg_r <= 1'b0;
              state <= MUL;
            end
`else
            rl    <= mag_b;
            mc    <= mag_a;
            neg_q <= sa ^ sb;
            state <= MUL;
`endif
          end
        end
        MUL: begin
          rh  <= mul_sum[32:1];
          rl  <= {mul_sum[0], rl[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          rh  <= rem_ge ? (rem_shift[31:0] - mc) : rem_shift[31:0];
          rl  <= {rl[30:0], rem_ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
`endif
        FIX: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
          if (op_div) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
`else
          {hi_q, lo_q} <= prod_fix;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - self-checking bench for muldiv: vector table, corner sequences, random vs model
module tb_muldiv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {hi, lo} computed from the arithmetic definition of each operation
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] qv;
    logic [63:0] rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return {32'd0, x} * {32'd0, y};
      2'd1: return 64'(sx * sy);
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        q  = sx / sy;
        r  = sx % sy;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          n;
    bit          hold_ok;
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    n = 1;
    hold_ok = 1'b1;
    while (!bus.done && n < 40) begin
      if (!bus.busy || bus.hi !== hi0 || bus.lo !== lo0) hold_ok = 1'b0;
      tick();
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd34);
    chk({nm, "_hold"}, 64'(hold_ok), 64'd1);
    chk({nm, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({nm, "_result"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    tick();
    chk({nm, "_done_once"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    bit          seen;
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] e;
    logic [31:0] hi0;
    logic [31:0] lo0;

    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
    bus.wd    = 32'd0;

    vecs.push_back('{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"});
    vecs.push_back('{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7"});
    vecs.push_back('{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin"});
    vecs.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1xm1"});
    vecs.push_back('{2'd0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, "multu_zero"});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2"});
    vecs.push_back('{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"});
    vecs.push_back('{2'd2, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu_by_zero"});
    vecs.push_back('{2'd3, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_by_zero"});
    vecs.push_back('{2'd2, 32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003, "divu_10by3"});
    vecs.push_back('{2'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7bym2"});
`endif

    tick();
    tick();
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;

    // start and MTHI while busy are ignored, then a start in the done cycle, then reset mid-operation
    bus.op = 2'd0;
    bus.a = 32'd5;
    bus.b = 32'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (n < 5) begin
      tick();
      n++;
    end
    bus.a = 32'd9;
    bus.start = 1'b1;
    bus.we_hi = 1'b1;
    bus.wd = 32'h1234;
    tick();
    n++;
    bus.start = 1'b0;
    bus.we_hi = 1'b0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk("seq_latency", 64'(n), 64'd34);
    chk("seq_result", {bus.hi, bus.lo}, {32'd0, 32'd30});
    bus.a = 32'd7;
    bus.b = 32'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("seq_restart_busy", 64'(bus.busy), 64'd1);
    chk("seq_restart_done", 64'(bus.done), 64'd0);
    n = 1;
    while (n < 10) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    do_op(2'd0, 32'd3, 32'd4, 32'd0, 32'd12, "first_after_reset");

    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

    // write in the accepting cycle lands, then the result overwrites it
    bus.op = 2'd0;
    bus.a = 32'd2;
    bus.b = 32'd3;
    bus.start = 1'b1;
    bus.we_hi = 1'b1;
    bus.wd = 32'hDEAD;
    tick();
    bus.start = 1'b0;
    bus.we_hi = 1'b0;
    chk("start_write_hi", 64'(bus.hi), 64'h0000DEAD);
    n = 1;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk("start_write_latency", 64'(n), 64'd34);
    chk("start_write_result", {bus.hi, bus.lo}, {32'd0, 32'd6});

    for (int k = 0; k < 24; k++) begin
`ifdef MULDIV_DIV_EN
      o = 2'($urandom_range(0, 3));
`else
      o = 2'($urandom_range(0, 1));
`endif
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'd0;
        1: y = $urandom_range(1, 9);
        2: y = -($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      e = model(o, x, y);
      do_op(o, x, y, e[63:32], e[31:0], $sformatf("rand%0d_op%0d", k, o));
    end

`ifndef MULDIV_DIV_EN
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.op = 2'd2;
    bus.a = 32'd10;
    bus.b = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (bus.busy || bus.done) seen = 1'b1;
      tick();
    end
    chk("nodiv_ignored", 64'(seen), 64'd0);
    chk("nodiv_hilo", {bus.hi, bus.lo}, {hi0, lo0});
`endif

    bus.we_lo = 1'b1;
    bus.wd = 32'hA5A5A5A5;
    tick();
    bus.we_lo = 1'b0;
    chk("mtlo", 64'(bus.lo), 64'hA5A5A5A5);
    bus.we_hi = 1'b1;
    bus.wd = 32'h5A5A0F0F;
    tick();
    bus.we_hi = 1'b0;
    chk("mthi", {bus.hi, bus.lo}, {32'h5A5A0F0F, 32'hA5A5A5A5});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset; asserted at 0.
REQ-004 start  in  1  request to begin an operation; sampled on the rising clk edge.
REQ-005 op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  in  32  rs operand: multiplicand or dividend.
REQ-007 b  in  32  rt operand: multiplier or divisor.
REQ-008 we_hi  in  1  MTHI write enable.
REQ-009 we_lo  in  1  MTLO write enable.
REQ-010 wd  in  32  MTHI/MTLO write data.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle pulse; results are valid on hi/lo in this cycle.
REQ-013 hi  out  32  architectural HI register.
REQ-014 lo  out  32  architectural LO register.

Function
REQ-015 The block SHALL implement the FSM states IDLE, MUL, DIV and FIX.
- IDLE -> MUL when start=1 and op[1]=0.
- IDLE -> DIV when start=1 and op[1]=1.
- MUL or DIV -> FIX after 32 iterations.
- FIX -> IDLE.
REQ-016 start SHALL be accepted only when busy=0, which includes the done cycle; start while busy=1 SHALL be ignored.
REQ-017 On acceptance, the block SHALL capture op, |a| and |b| (magnitudes for signed ops, raw values for unsigned ops) and the result signs into internal registers.
REQ-018 Subsequent changes on a and b SHALL have no effect on the operation in progress.
REQ-019 MUL SHALL perform one radix-2 shift-add step per cycle; DIV SHALL perform one restoring shift-subtract step per cycle, for 32 cycles in each case.
REQ-020 FIX SHALL apply sign correction and write hi/lo.
REQ-021 Latency: busy=1 for exactly 33 cycles after the accepting edge; hi/lo SHALL update on the 33rd edge after acceptance, and done=1 with busy=0 in the following cycle.
REQ-022 Multiply: {hi,lo} SHALL equal the full 64-bit product, signed for MULT and unsigned for MULTU.
REQ-023 Divide: lo SHALL equal the quotient truncated toward zero and hi SHALL equal the remainder, which takes the sign of the dividend.
REQ-024 Divide by zero (DIV or DIVU) SHALL give lo=32'hFFFFFFFF and hi=a, with normal latency.
REQ-025 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-026 hi/lo SHALL hold their value while busy=1; partial results SHALL stay internal until FIX.
REQ-027 we_hi/we_lo with busy=0 SHALL write wd to hi/lo on the edge; while busy=1 they SHALL be ignored.
REQ-028 If start and we_hi/we_lo are asserted in the same cycle, the write SHALL occur and the operation SHALL later overwrite hi/lo.
REQ-029 done SHALL never be asserted for more than one consecutive cycle unless a new start is accepted in the done cycle, in which case done follows again 33 cycles later.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force FSM=IDLE, busy=0, done=0, hi=0, lo=0 and all internal registers to 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-032 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-033 Macro MULDIV_DIV_EN defined: DIVU/DIV SHALL be fully supported per REQ-023 to REQ-025.
REQ-034 MULDIV_DIV_EN undefined: the DIV state and divide datapath SHALL be absent; start with op[1]=1 SHALL be ignored (busy stays 0, no done pulse, hi/lo unchanged), and MULT/MULTU SHALL be unaffected.

Verification
REQ-035 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> done 34 cycles after start; hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-036 MULT a=32'hFFFFFFFD (-3), b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB (-21).
REQ-037 DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIV 32'h80000000 by 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-038 DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=32'h00000064.
REQ-039 Start MULTU 5*6, then start with a=9 plus we_hi with wd=32'h1234 at busy cycle 5, then start in the done cycle -> second start and write ignored, hi=0, lo=30, new operation begins; reset=0 at its cycle 10 -> busy=0, hi=lo=0, no done pulse.
REQ-040 Build without MULDIV_DIV_EN: DIVU 10/3 -> busy stays 0, no done, hi/lo unchanged; MTLO wd=32'hA5A5A5A5 -> lo=32'hA5A5A5A5 the next cycle.
